// File: rtl/debounce_sync.sv
// debounce_sync: synchronises a raw asynchronous input, rejects bounce and
// glitches, and emits a clean registered level with one-cycle change strobes.
module debounce_sync #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned CNT_WIDTH       = 16,
    parameter logic        RESET_LEVEL     = 1'b0
) (
    input  logic clk,
    input  logic reset_async,
    input  logic reset_sync,
    input  logic enable,
    input  logic din_raw,
    output logic dout,
    output logic dout_valid,
    output logic rise,
    output logic fall,
    output logic busy
);

    typedef enum logic {
        STABLE = 1'b0,
        CHECK  = 1'b1
    } state_e;

    localparam logic [CNT_WIDTH-1:0] TERM_CNT = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    // Reject illegal parameterisations at elaboration time
    generate
        if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
            $fatal(1, "debounce_sync: SYNC_STAGES must be in 2..4");
        end
        if (DEBOUNCE_CYCLES < 1) begin : g_bad_deb
            $fatal(1, "debounce_sync: DEBOUNCE_CYCLES must be >= 1");
        end
        if (CNT_WIDTH < 32) begin : g_cnt_chk
            if (((DEBOUNCE_CYCLES - 1) >> CNT_WIDTH) != 0) begin : g_bad_cnt
                $fatal(1, "debounce_sync: CNT_WIDTH too small for DEBOUNCE_CYCLES-1");
            end
        end
    endgenerate

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   din_s;

    state_e                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic                   dout_q, dout_d;
    logic                   valid_q, valid_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   busy_q, busy_d;

    assign din_s = sync_q[SYNC_STAGES-1];

    // Synchronizer chain, free-running (not gated by enable)
    always_ff @(posedge clk or posedge reset_async) begin
        if (reset_async) begin
            sync_q <= {SYNC_STAGES{RESET_LEVEL}};
        end else if (reset_sync) begin
            sync_q <= {SYNC_STAGES{RESET_LEVEL}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din_raw};
        end
    end

    // FSM state, counter and registered outputs
    always_ff @(posedge clk or posedge reset_async) begin
        if (reset_async) begin
            state_q <= STABLE;
            cnt_q   <= '0;
            dout_q  <= RESET_LEVEL;
            valid_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else if (reset_sync) begin
            state_q <= STABLE;
            cnt_q   <= '0;
            dout_q  <= RESET_LEVEL;
            valid_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state: glitch rejection outranks a same-cycle terminal count
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        valid_d = 1'b0;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (state_q)
            STABLE: begin
                if (din_s != dout_q) begin
                    state_d = CHECK;
                    cnt_d   = '0;
                end
            end
            CHECK: begin
                if (din_s == dout_q) begin
                    state_d = STABLE;
                    cnt_d   = '0;
                end else if (enable && (cnt_q == TERM_CNT)) begin
                    dout_d  = din_s;
                    valid_d = 1'b1;
                    rise_d  = din_s;
                    fall_d  = ~din_s;
                    state_d = STABLE;
                    cnt_d   = '0;
                end else if (enable) begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end
            default: begin
                state_d = STABLE;
                cnt_d   = '0;
            end
        endcase
        busy_d = (state_d == CHECK);
    end

    assign dout       = dout_q;
    assign dout_valid = valid_q;
    assign rise       = rise_q;
    assign fall       = fall_q;
    assign busy       = busy_q;

endmodule
